// File: rtl/uart_calc_printer.sv
// uart_calc_printer: receives a command byte plus signed little-endian operands,
// computes square / product / sum in 2W bits, converts the result to signed
// decimal ASCII with a bit-serial divide-by-10 and prints it followed by CR LF.
module uart_calc_printer #(
   parameter int OPERAND_BYTES  = 4,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  rx_data,
   input  logic                        new_rx_data,
   output logic [7:0]                  tx_data,
   output logic                        new_tx_data,
   input  logic                        tx_busy,
   output logic                        busy,
   output logic                        err,
   output logic [16*OPERAND_BYTES-1:0] last_result
);

   localparam int W    = 8 * OPERAND_BYTES;
   localparam int RW   = 2 * W;
   // ceil(RW*log10(2)) + 1 digit slots
   localparam int NDIG = (RW * 30103 + 99999) / 100000 + 1;
   localparam int DW   = $clog2(NDIG + 1);
   localparam int NBUF = 1 << DW;
   localparam int CW   = $clog2(2 * OPERAND_BYTES + 1);
   localparam int BW   = $clog2(RW);

   typedef enum logic [2:0] {S_IDLE, S_RECV, S_CALC, S_CONV, S_PRINT} state_t;
   typedef enum logic [1:0] {C_SQR, C_MUL, C_ADD} cmd_t;
   typedef enum logic [1:0] {P_SIGN, P_DIG, P_CR, P_LF} phase_t;

   state_t          state_r;
   cmd_t            cmd_r;
   phase_t          phase_r;
   logic [W-1:0]    opa_r;
   logic [W-1:0]    opb_r;
   logic [CW-1:0]   cnt_r;
   logic [31:0]     timer_r;
   logic            sign_r;
   logic [RW-1:0]   mag_r;
   logic [3:0]      rem_r;
   logic [BW-1:0]   bit_r;
   logic [DW-1:0]   ndig_r;
   logic [DW-1:0]   didx_r;
   logic [3:0]      dig_r [NBUF];
   logic [7:0]      tx_data_r;
   logic            new_tx_data_r;
   logic            busy_r;
   logic            err_r;
   logic [RW-1:0]   last_result_r;

   logic [RW-1:0]   a_ext_s;
   logic [RW-1:0]   b_ext_s;
   logic [RW-1:0]   calc_s;
   logic [RW-1:0]   mag_calc_s;
   logic [W+7:0]    a_cat_s;
   logic [W+7:0]    b_cat_s;
   logic [CW-1:0]   nbytes_s;
   logic            last_byte_s;
   logic            to_a_s;
   logic            expire_s;
   logic [4:0]      div_t_s;
   logic            div_ge_s;
   logic [3:0]      div_rem_s;
   logic [RW-1:0]   q_nx_s;

   assign a_ext_s     = {{W{opa_r[W-1]}}, opa_r};
   assign b_ext_s     = {{W{opb_r[W-1]}}, opb_r};
   assign a_cat_s     = {rx_data, opa_r};
   assign b_cat_s     = {rx_data, opb_r};
   assign nbytes_s    = (cmd_r == C_SQR) ? CW'(OPERAND_BYTES) : CW'(2 * OPERAND_BYTES);
   assign last_byte_s = (cnt_r == nbytes_s - CW'(1));
   assign to_a_s      = (cnt_r < CW'(OPERAND_BYTES));
   assign expire_s    = (TIMEOUT_CYCLES != 0) && (timer_r == 32'(TIMEOUT_CYCLES - 1));
   assign mag_calc_s  = calc_s[RW-1] ? (-calc_s) : calc_s;

   // one restoring divide-by-10 step: shift the next magnitude bit into the remainder
   assign div_t_s   = {rem_r, mag_r[RW-1]};
   assign div_ge_s  = (div_t_s >= 5'd10);
   assign div_rem_s = div_ge_s ? 4'(div_t_s - 5'd10) : div_t_s[3:0];
   assign q_nx_s    = {mag_r[RW-2:0], div_ge_s};

   // arithmetic on sign-extended operands; truncation to RW bits keeps two's complement exact
   always_comb begin
      calc_s = {RW{1'b0}};
      case (cmd_r)
         C_SQR:   calc_s = a_ext_s * a_ext_s;
         C_MUL:   calc_s = a_ext_s * b_ext_s;
         C_ADD:   calc_s = a_ext_s + b_ext_s;
         default: calc_s = {RW{1'b0}};
      endcase
   end

   // command FSM: receive, calculate, convert to decimal, print
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= S_IDLE;
         cmd_r         <= C_SQR;
         phase_r       <= P_SIGN;
         opa_r         <= {W{1'b0}};
         opb_r         <= {W{1'b0}};
         cnt_r         <= {CW{1'b0}};
         timer_r       <= 32'd0;
         sign_r        <= 1'b0;
         mag_r         <= {RW{1'b0}};
         rem_r         <= 4'd0;
         bit_r         <= {BW{1'b0}};
         ndig_r        <= {DW{1'b0}};
         didx_r        <= {DW{1'b0}};
         tx_data_r     <= 8'h00;
         new_tx_data_r <= 1'b0;
         busy_r        <= 1'b0;
         err_r         <= 1'b0;
         last_result_r <= {RW{1'b0}};
         for (int i = 0; i < NBUF; i++) begin
            dig_r[i] <= 4'd0;
         end
      end else begin
         new_tx_data_r <= 1'b0;
         err_r         <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (new_rx_data) begin
                  opa_r   <= {W{1'b0}};
                  opb_r   <= {W{1'b0}};
                  cnt_r   <= {CW{1'b0}};
                  timer_r <= 32'd0;
                  case (rx_data)
                     8'h73: begin cmd_r <= C_SQR; state_r <= S_RECV; busy_r <= 1'b1; end
                     8'h6D: begin cmd_r <= C_MUL; state_r <= S_RECV; busy_r <= 1'b1; end
                     8'h61: begin cmd_r <= C_ADD; state_r <= S_RECV; busy_r <= 1'b1; end
                     default: state_r <= S_IDLE;
                  endcase
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_RECV: begin
               if (new_rx_data && last_byte_s) begin
                  // the completing byte wins over a simultaneous timeout
                  if (to_a_s) opa_r <= a_cat_s[W+7:8];
                  else        opb_r <= b_cat_s[W+7:8];
                  state_r <= S_CALC;
               end else if (expire_s) begin
                  err_r   <= 1'b1;
                  busy_r  <= 1'b0;
                  opa_r   <= {W{1'b0}};
                  opb_r   <= {W{1'b0}};
                  cnt_r   <= {CW{1'b0}};
                  timer_r <= 32'd0;
                  state_r <= S_IDLE;
               end else if (new_rx_data) begin
                  if (to_a_s) opa_r <= a_cat_s[W+7:8];
                  else        opb_r <= b_cat_s[W+7:8];
                  cnt_r   <= cnt_r + CW'(1);
                  timer_r <= 32'd0;
               end else begin
                  timer_r <= timer_r + 32'd1;
               end
            end
            S_CALC: begin
               last_result_r <= calc_s;
               sign_r        <= calc_s[RW-1];
               mag_r         <= mag_calc_s;
               rem_r         <= 4'd0;
               bit_r         <= {BW{1'b0}};
               ndig_r        <= {DW{1'b0}};
               state_r       <= S_CONV;
            end
            S_CONV: begin
               mag_r <= q_nx_s;
               if (bit_r == BW'(RW - 1)) begin
                  dig_r[ndig_r] <= div_rem_s;
                  ndig_r        <= ndig_r + DW'(1);
                  rem_r         <= 4'd0;
                  bit_r         <= {BW{1'b0}};
                  if (q_nx_s == {RW{1'b0}}) begin
                     didx_r  <= ndig_r;
                     phase_r <= sign_r ? P_SIGN : P_DIG;
                     state_r <= S_PRINT;
                  end else begin
                     state_r <= S_CONV;
                  end
               end else begin
                  rem_r <= div_rem_s;
                  bit_r <= bit_r + BW'(1);
               end
            end
            S_PRINT: begin
               // issue only when the transmitter is free and the previous cycle was idle
               if (!tx_busy && !new_tx_data_r) begin
                  new_tx_data_r <= 1'b1;
                  case (phase_r)
                     P_SIGN: begin
                        tx_data_r <= 8'h2D;
                        phase_r   <= P_DIG;
                     end
                     P_DIG: begin
                        tx_data_r <= {4'h3, dig_r[didx_r]};
                        if (didx_r == {DW{1'b0}}) phase_r <= P_CR;
                        else                      didx_r  <= didx_r - DW'(1);
                     end
                     P_CR: begin
                        tx_data_r <= 8'h0D;
                        phase_r   <= P_LF;
                     end
                     P_LF: begin
                        tx_data_r <= 8'h0A;
                        busy_r    <= 1'b0;
                        state_r   <= S_IDLE;
                     end
                     default: begin
                        new_tx_data_r <= 1'b0;
                        busy_r        <= 1'b0;
                        state_r       <= S_IDLE;
                     end
                  endcase
               end else begin
                  state_r <= S_PRINT;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_data     = tx_data_r;
   assign new_tx_data = new_tx_data_r;
   assign busy        = busy_r;
   assign err         = err_r;
   assign last_result = last_result_r;

endmodule

// File: tb/tb_uart_calc_printer.sv
// Testbench for uart_calc_printer: directed table from the test plan, randomized
// commands against a decimal-formatting reference model, and hand-written
// sequences for timeout, transmit stall and reset during printing.
module tb_uart_calc_printer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        new_rx_data;
   logic        tx_busy;
   logic        hold_busy;
   logic [7:0]  tx_data;
   logic        new_tx_data;
   logic        busy;
   logic        err;
   logic [63:0] last_result;

   int nvec = 0;
   int nerr = 0;

   logic [7:0] txq [$];
   int         viol_cnt = 0;
   int         err_cnt  = 0;
   logic       prev_ntx = 1'b0;
   logic       prev_busy = 1'b0;
   int         busy_cnt = 0;

   typedef struct packed {
      logic [7:0]      cmd;
      logic [31:0]     a;
      logic [31:0]     b;
      logic [63:0]     exp_res;
      logic [5:0]      exp_len;
      logic [8*24-1:0] exp_txt;
   } vec_t;

   vec_t tbl [7];

   always #5 clk = ~clk;

   uart_calc_printer #(.OPERAND_BYTES(4), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
      .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
      .busy(busy), .err(err), .last_result(last_result)
   );

   // transmitter stand-in: busy for three cycles after each accepted request
   always @(posedge clk) begin
      if (rst) busy_cnt <= 0;
      else if (new_tx_data && !tx_busy) busy_cnt <= 3;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0) || hold_busy;

   // capture transmitted bytes and flag back-to-back or busy-ignoring requests
   always @(negedge clk) begin
      if (new_tx_data) begin
         txq.push_back(tx_data);
         if (prev_ntx || prev_busy) viol_cnt <= viol_cnt + 1;
      end
      if (err) err_cnt <= err_cnt + 1;
      prev_ntx  <= new_tx_data;
      prev_busy <= tx_busy;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      new_rx_data = 1'b1;
      @(posedge clk); #1;
      new_rx_data = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b);
      send_byte(cmd);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
      if (cmd != 8'h73) begin
         for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done"}, 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_line(input string name, input int base, input logic [5:0] exp_len,
                             input logic [8*24-1:0] exp_txt, input logic [63:0] exp_res);
      int L = int'(exp_len);
      logic [7:0] act;
      logic [7:0] expb;
      chk({name, "_len"}, 64'(txq.size() - base), 64'(L));
      for (int i = 0; i < L; i++) begin
         act  = (base + i < txq.size()) ? txq[base + i] : 8'h00;
         expb = exp_txt[8*(L-1-i) +: 8];
         chk($sformatf("%s_byte%0d", name, i), 64'(act), 64'(expb));
      end
      chk({name, "_last_result"}, last_result, exp_res);
   endtask

   // reference: plain signed arithmetic, then decimal text via string formatting
   function automatic logic [63:0] model_res(input logic [7:0] cmd, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      if (cmd == 8'h73)      return 64'(sa * sa);
      else if (cmd == 8'h6D) return 64'(sa * sb);
      else                   return 64'(sa + sb);
   endfunction

   task automatic model_text(input logic [63:0] res, output logic [5:0] len,
                             output logic [8*24-1:0] txt);
      string s = $sformatf("%0d", $signed(res));
      txt = '0;
      for (int i = 0; i < s.len(); i++) txt = {txt[8*23-1:0], s[i]};
      txt = {txt[8*22-1:0], 8'h0D, 8'h0A};
      len = 6'(s.len() + 2);
   endtask

   initial begin
      int base;
      int e0;
      int sz;
      int n;
      logic [7:0]      rc;
      logic [31:0]     ra;
      logic [31:0]     rb;
      logic [63:0]     rres;
      logic [5:0]      rlen;
      logic [8*24-1:0] rtxt;

      tbl[0] = '{8'h73, 32'h00000005, 32'h00000000, 64'd25, 6'd4, 192'("25\r\n")};
      tbl[1] = '{8'h6D, 32'hFFFFFFFF, 32'h00000007, 64'hFFFF_FFFF_FFFF_FFF9, 6'd4, 192'("-7\r\n")};
      tbl[2] = '{8'h73, 32'h80000000, 32'h00000000, 64'h4000_0000_0000_0000, 6'd21,
                 192'("4611686018427387904\r\n")};
      tbl[3] = '{8'h61, 32'h00000000, 32'h00000000, 64'd0, 6'd3, 192'("0\r\n")};
      tbl[4] = '{8'h61, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h0000_0000_FFFF_FFFE, 6'd12,
                 192'("4294967294\r\n")};
      tbl[5] = '{8'h6D, 32'h80000000, 32'h7FFFFFFF, 64'hC000_0000_8000_0000, 6'd22,
                 192'("-4611686016279904256\r\n")};
      tbl[6] = '{8'h61, 32'h80000000, 32'h80000000, 64'hFFFF_FFFF_0000_0000, 6'd13,
                 192'("-4294967296\r\n")};

      rst = 1'b1;
      rx_data = 8'h00;
      new_rx_data = 1'b0;
      hold_busy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_new_tx_data", 64'(new_tx_data), 64'd0);
      chk("rst_tx_data", 64'(tx_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_last_result", last_result, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // directed table
      for (int t = 0; t < 7; t++) begin
         base = txq.size();
         send_cmd(tbl[t].cmd, tbl[t].a, tbl[t].b);
         wait_idle($sformatf("tbl%0d", t));
         check_line($sformatf("tbl%0d", t), base, tbl[t].exp_len, tbl[t].exp_txt, tbl[t].exp_res);
      end

      // randomized commands against the reference model
      for (int t = 0; t < 20; t++) begin
         case ($urandom_range(0, 2))
            0:       rc = 8'h73;
            1:       rc = 8'h6D;
            default: rc = 8'h61;
         endcase
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 20)) - 32'd10;
         if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 20)) - 32'd10;
         rres = model_res(rc, ra, rb);
         model_text(rres, rlen, rtxt);
         base = txq.size();
         send_cmd(rc, ra, rb);
         wait_idle($sformatf("rnd%0d", t));
         check_line($sformatf("rnd%0d", t), base, rlen, rtxt, rres);
      end

      // inter-byte timeout, then an ignored command byte, then recovery
      e0 = err_cnt;
      base = txq.size();
      send_byte(8'h73);
      send_byte(8'h01);
      send_byte(8'h02);
      repeat (150) @(posedge clk);
      @(negedge clk);
      chk("timeout_err_pulses", 64'(err_cnt - e0), 64'd1);
      chk("timeout_no_tx", 64'(txq.size() - base), 64'd0);
      chk("timeout_busy", 64'(busy), 64'd0);
      send_byte(8'h78);
      repeat (5) @(negedge clk);
      chk("ignored_busy", 64'(busy), 64'd0);
      chk("ignored_no_tx", 64'(txq.size() - base), 64'd0);
      send_cmd(8'h73, 32'h00000003, 32'h00000000);
      wait_idle("after_timeout");
      check_line("after_timeout", base, 6'd3, 192'("9\r\n"), 64'd9);

      // transmitter stalled for 200 cycles after the second byte
      base = txq.size();
      send_cmd(8'h73, 32'h00000005, 32'h00000000);
      n = 0;
      while (txq.size() - base < 2 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      hold_busy = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      chk("stall_held_bytes", 64'(txq.size() - base), 64'd2);
      hold_busy = 1'b0;
      wait_idle("stall");
      check_line("stall", base, 6'd4, 192'("25\r\n"), 64'd25);

      // reset in the middle of printing a long line
      base = txq.size();
      send_cmd(8'h73, 32'h80000000, 32'h00000000);
      n = 0;
      while (txq.size() - base < 3 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_new_tx_data", 64'(new_tx_data), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_last_result", last_result, 64'd0);
      sz = txq.size();
      repeat (100) @(negedge clk);
      chk("midrst_no_more_tx", 64'(txq.size() - sz), 64'd0);
      chk("midrst_partial", 64'(txq.size() - base < 21), 64'd1);

      // recovery after reset
      base = txq.size();
      send_cmd(8'h6D, 32'hFFFFFFFD, 32'h00000004);
      wait_idle("recover");
      check_line("recover", base, 6'd5, 192'("-12\r\n"), 64'hFFFF_FFFF_FFFF_FFF4);

      chk("tx_spacing_violations", 64'(viol_cnt), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/uart_calc_printer.md
Name: uart_calc_printer

Overview:
- Successor to the fixed 4-byte square-and-print UART block.
- Receives a one-byte command plus one or two signed binary operands of parametrised width over the UART RX byte interface, then computes square, product or sum.
- Converts the result to signed decimal ASCII without an external ROM, and sends it followed by CR LF over the UART TX byte interface.
- Sits between the serial RX/TX wrappers and the top level; last_result drives the board LEDs.

Parameters:
- OPERAND_BYTES, 4: operand width W = 8*OPERAND_BYTES bits, signed two's complement, little-endian on the wire; must be 1 to 8.
- TIMEOUT_CYCLES, 50000000: maximum clk cycles allowed between RX bytes inside a command; 0 disables the timeout.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- rx_data  input  8  received byte, valid when new_rx_data=1.
- new_rx_data  input  1  one-cycle strobe per received byte.
- tx_data  output  8  byte to transmit, valid while new_tx_data=1.
- new_tx_data  output  1  one-cycle transmit request.
- tx_busy  input  1  transmitter busy; rises the cycle after an accepted request.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle pulse on inter-byte timeout.
- last_result  output  2W  signed result of the last completed calculation.

Behaviour:
- Reset values: state IDLE; new_tx_data 0; tx_data 0; busy 0; err 0; last_result 0; operand registers, byte counter and timer 0. Reset applies in any state, including mid-RX or mid-print; the partial line is abandoned and no further bytes are requested.
- States: IDLE -> RECV -> CALC -> CONV -> PRINT -> IDLE.
- IDLE: on new_rx_data, the byte selects the command and the state moves to RECV:
  - 's' (0x73): square A, 1 operand.
  - 'm' (0x6D): A*B, 2 operands.
  - 'a' (0x61): A+B, 2 operands.
  - Any other byte is ignored; the block stays in IDLE with no output.
- RECV: each strobe stores rx_data into the next byte of A, then B, least-significant byte first. The counter is OPERAND_BYTES*(1 or 2); after the last byte, go to CALC.
  - The timer clears on every byte.
  - When the timer reaches TIMEOUT_CYCLES: pulse err, discard the operands, return to IDLE, transmit nothing.
- CALC: one cycle. A and B are sign-extended to 2W.
  - result = A*A, A*B, or A+B; this never overflows 2W.
  - last_result updates at the end of this cycle.
- CONV: split result into a sign flag and magnitude. Produce decimal digits with a sequential divide-by-10, LSD first, into a digit buffer of ceil(2W*log10(2))+1 entries.
  - Conversion stops when the quotient is 0; at least one digit is always produced, so 0 prints "0".
  - Latency is implementation-defined but bounded by digits*(2W+2)+4 cycles.
- PRINT: send '-' (0x2D) if negative, then the digits MSD first with no leading zeros, then 0x0D, 0x0A; then go to IDLE.
  - A byte is issued only when tx_busy=0.
  - At least one idle cycle separates consecutive new_tx_data pulses.
  - tx_data is stable during the pulse.
  - Holding tx_busy high for any time stalls PRINT without loss or duplication of bytes.
- RX strobes in CALC, CONV and PRINT are ignored and not buffered.
- A strobe in the same cycle as a timeout expiry is discarded; the timeout wins.
- The byte that completes the operand is accepted even if the timer would expire in that cycle.

Test Plan:
- OPERAND_BYTES=4: send 's',05,00,00,00 -> TX "25\r\n" (32 35 0D 0A); last_result=25; busy returns to 0.
- 'm', A=FF FF FF FF (-1), B=07 00 00 00 -> TX "-7\r\n"; last_result=64'hFFFF_FFFF_FFFF_FFF9.
- 's', A=00 00 00 80 (-2^31) -> TX "4611686018427387904\r\n" (19 digits, no sign).
- 'a' with A=0 and B=0 -> TX "0\r\n"; 'a' with A=7FFFFFFF and B=7FFFFFFF -> TX "4294967294\r\n".
- TIMEOUT_CYCLES=100: 's',01,02 then 150 idle cycles -> one err pulse, no TX. Then 'x' -> ignored. Then 's',03,00,00,00 -> "9\r\n".
- Hold tx_busy high for 200 cycles after the 2nd byte -> remaining bytes resume in order. Repeat with rst asserted mid-PRINT -> new_tx_data=0 the next cycle, busy=0, last_result=0, no further TX bytes.
